// File: rtl/phase_detector_if.sv
// phase_detector_if: bundles the oscillator inputs and the controller-facing
// verdict outputs of the bang-bang phase/frequency detector.
//   master : the side that owns the oscillators and consumes the verdict
//   slave  : the phase detector itself
interface phase_detector_if #(
  parameter int CNT_W = 8
);
  logic             ref_in;
  logic             dco_in;
  logic             p_up;
  logic             p_down;
  logic             phase_clk;
  logic [CNT_W-1:0] phase_err;
  logic             dropped;

  modport master (
    output ref_in, dco_in,
    input  p_up, p_down, phase_clk, phase_err, dropped
  );

  modport slave (
    input  ref_in, dco_in,
    output p_up, p_down, phase_clk, phase_err, dropped
  );
endinterface

// File: rtl/phase_detector.sv
// phase_detector: sampled bang-bang phase/frequency detector.
// Oversamples ref_in and dco_in on sample_clk, finds their rising edges,
// measures which one led and by how many sample cycles, and presents the
// verdict (p_up/p_down/phase_err) with a generated phase_clk strobe.
//
// Optional feature macro: PD_SYNC_EN
//   defined   : each input goes through a 2-flop synchronizer
//   undefined : each input goes through a single capture flop
module phase_detector #(
  parameter int CNT_W     = 8,
  parameter int DEAD_ZONE = 1,
  parameter int TIMEOUT   = 255,
  parameter int PULSE_W   = 4
) (
  input  logic           sample_clk,
  input  logic           reset,
  phase_detector_if.slave pd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAG    = 2'd1;  // reference edge came first
  localparam logic [1:0] ST_LEAD   = 2'd2;  // DCO edge came first
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam int RPT_W = $clog2(PULSE_W + 2);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD_ZONE);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(PULSE_W + 1);
  localparam logic [RPT_W-1:0] PULSE_END = RPT_W'(PULSE_W);

  logic ref_s;
  logic dco_s;
  logic ref_hist_q;
  logic dco_hist_q;
  logic ref_edge;
  logic dco_edge;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [RPT_W-1:0] rpt_q,     rpt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic             enter_rpt;
  logic [CNT_W-1:0] err_d;
  logic             dir_up_d;
  logic             dir_dn_d;

  logic             p_up_q;
  logic             p_down_q;
  logic             phase_clk_q;
  logic [CNT_W-1:0] phase_err_q;
  logic             dropped_q;

`ifdef PD_SYNC_EN
  logic ref_meta_q;
  logic ref_sync_q;
  logic dco_meta_q;
  logic dco_sync_q;

  // Two-flop synchronizers for the asynchronous oscillator inputs.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours, as real flip-flops do.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      ref_meta_q <= 1'b0;
      ref_sync_q <= 1'b0;
      dco_meta_q <= 1'b0;
      dco_sync_q <= 1'b0;
    end else begin
      ref_meta_q <= pd.ref_in;
      ref_sync_q <= ref_meta_q;
      dco_meta_q <= pd.dco_in;
      dco_sync_q <= dco_meta_q;
    end
  end

  assign ref_s = ref_sync_q;
  assign dco_s = dco_sync_q;
`else
  logic ref_cap_q;
  logic dco_cap_q;

  // Single capture flop per input (inputs already synchronous to sample_clk).
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours, as real flip-flops do.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      ref_cap_q <= 1'b0;
      dco_cap_q <= 1'b0;
    end else begin
      ref_cap_q <= pd.ref_in;
      dco_cap_q <= pd.dco_in;
    end
  end

  assign ref_s = ref_cap_q;
  assign dco_s = dco_cap_q;
`endif

  // History flops track the stage outputs in every state, so an edge that
  // arrives during REPORT is never re-detected later.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      ref_hist_q <= 1'b0;
      dco_hist_q <= 1'b0;
    end else begin
      ref_hist_q <= ref_s;
      dco_hist_q <= dco_s;
    end
  end

  assign ref_edge = ref_s & ~ref_hist_q;
  assign dco_edge = dco_s & ~dco_hist_q;
  assign cnt_inc  = cnt_q + 1'b1;

  // Measurement FSM: next state, counters and the verdict to latch on REPORT entry.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    enter_rpt = 1'b0;
    err_d     = '0;
    dir_up_d  = 1'b0;
    dir_dn_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        rpt_d = '0;
        if (ref_edge && dco_edge) begin
          enter_rpt = 1'b1;          // zero offset: no direction
        end else if (ref_edge) begin
          state_d = ST_LAG;
        end else if (dco_edge) begin
          state_d = ST_LEAD;
        end
      end

      ST_LAG: begin
        // A real DCO edge takes priority over a simultaneous second ref edge.
        if (dco_edge) begin
          enter_rpt = 1'b1;
          err_d     = cnt_inc;
          dir_dn_d  = 1'b1;
        end else if (ref_edge || (cnt_inc == TIMEOUT_C)) begin
          enter_rpt = 1'b1;
          err_d     = TIMEOUT_C;
          dir_dn_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
        end
      end

      ST_LEAD: begin
        if (ref_edge) begin
          enter_rpt = 1'b1;
          err_d     = cnt_inc;
          dir_up_d  = 1'b1;
        end else if (dco_edge || (cnt_inc == TIMEOUT_C)) begin
          enter_rpt = 1'b1;
          err_d     = TIMEOUT_C;
          dir_up_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
        end
      end

      ST_REPORT: begin
        // rpt_q: 0 = setup, 1..PULSE_W = strobe high, PULSE_W+1 = hold.
        if (rpt_q == RPT_LAST) begin
          state_d = ST_IDLE;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rpt_d   = '0;
      end
    endcase

    if (enter_rpt) begin
      state_d = ST_REPORT;
      cnt_d   = '0;
      rpt_d   = '0;
    end
  end

  // State, measurement counter and REPORT sequencer registers.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // Verdict outputs: loaded on REPORT entry and held until the next entry.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      p_up_q      <= 1'b0;
      p_down_q    <= 1'b0;
      phase_err_q <= '0;
    end else if (enter_rpt) begin
      p_up_q      <= dir_up_d && (err_d > DEAD_C);
      p_down_q    <= dir_dn_d && (err_d > DEAD_C);
      phase_err_q <= err_d;
    end
  end

  // Strobe and drop flag, registered from next-state so they are glitch-free.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      phase_clk_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      phase_clk_q <= (state_d == ST_REPORT) && (rpt_d != '0) && (rpt_d <= PULSE_END);
      dropped_q   <= (state_q == ST_REPORT) && (ref_edge || dco_edge);
    end
  end

  assign pd.p_up      = p_up_q;
  assign pd.p_down    = p_down_q;
  assign pd.phase_clk = phase_clk_q;
  assign pd.phase_err = phase_err_q;
  assign pd.dropped   = dropped_q;

endmodule

// File: tb/tb_phase_detector.sv
// tb_phase_detector: scoreboard bench for phase_detector. Each measurement
// pushes its expected verdict when the edges are driven; a monitor pops and
// compares on every phase_clk rising edge and checks the strobe width.
module tb_phase_detector;

  localparam int CNT_W     = 8;
  localparam int DEAD_ZONE = 1;
  localparam int TIMEOUT   = 255;
  localparam int PULSE_W   = 4;
`ifdef PD_SYNC_EN
  localparam int RISE_LAT  = 4;
`else
  localparam int RISE_LAT  = 3;
`endif

  typedef struct packed {
    logic             up;
    logic             dn;
    logic [CNT_W-1:0] err;
  } exp_t;

  logic sample_clk;
  logic reset;

  phase_detector_if #(.CNT_W(CNT_W)) pd_if ();

  phase_detector #(
    .CNT_W    (CNT_W),
    .DEAD_ZONE(DEAD_ZONE),
    .TIMEOUT  (TIMEOUT),
    .PULSE_W  (PULSE_W)
  ) dut (
    .sample_clk(sample_clk),
    .reset     (reset),
    .pd        (pd_if)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   reports_done = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare verdict on each strobe rise, strobe width on each fall.
  logic prev_pclk = 1'b0;
  logic prev_up   = 1'b0;
  logic prev_dn   = 1'b0;
  int   hi_cnt    = 0;

  always @(negedge sample_clk) begin
    exp_t e;
    if (reset) begin
      hi_cnt = 0;
    end else if (pd_if.phase_clk && !prev_pclk) begin
      if (sb_q.size() == 0) begin
        check("unexpected_report", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("p_up",        32'(pd_if.p_up),      32'(e.up));
        check("p_down",      32'(pd_if.p_down),    32'(e.dn));
        check("phase_err",   32'(pd_if.phase_err), 32'(e.err));
        check("setup_p_up",  32'(prev_up),         32'(e.up));
        check("setup_p_down",32'(prev_dn),         32'(e.dn));
      end
      hi_cnt = 1;
    end else if (pd_if.phase_clk) begin
      hi_cnt++;
    end else if (prev_pclk) begin
      check("pulse_width", 32'(hi_cnt), 32'(PULSE_W));
      reports_done++;
    end
    prev_pclk = pd_if.phase_clk;
    prev_up   = pd_if.p_up;
    prev_dn   = pd_if.p_down;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (reports_done < target && n < 600) begin
      @(negedge sample_clk);
      n++;
    end
    check("report_done", 32'(reports_done >= target), 32'd1);
  endtask

  task automatic wait_pclk_high(output int n);
    n = 0;
    do begin
      @(negedge sample_clk);
      n++;
    end while (!pd_if.phase_clk && n < 40);
  endtask

  // One measurement: leading edge, gap cycles, lagging edge; verdict modelled here.
  task automatic measure(input bit dco_first, input int gap, input bit chk_lat);
    exp_t e;
    int   target;
    int   n;
    target = reports_done + 1;
    e.err  = CNT_W'(gap);
    e.up   = dco_first  && (gap > DEAD_ZONE);
    e.dn   = !dco_first && (gap > DEAD_ZONE);
    sb_q.push_back(e);
    if (gap == 0) begin
      pd_if.ref_in = 1'b1;
      pd_if.dco_in = 1'b1;
    end else begin
      if (dco_first) pd_if.dco_in = 1'b1; else pd_if.ref_in = 1'b1;
      cyc(gap);
      if (dco_first) pd_if.ref_in = 1'b1; else pd_if.dco_in = 1'b1;
    end
    if (chk_lat) begin
      wait_pclk_high(n);
      check("rise_latency", 32'(n), 32'(RISE_LAT));
    end
    wait_done(target);
    pd_if.ref_in = 1'b0;
    pd_if.dco_in = 1'b0;
    cyc(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    int   target;
    reset        = 1'b1;
    pd_if.ref_in = 1'b0;
    pd_if.dco_in = 1'b0;

    // Reset held 3 cycles with inputs toggling: every output stays 0.
    @(negedge sample_clk);
    for (int i = 0; i < 3; i++) begin
      pd_if.ref_in = ~pd_if.ref_in;
      pd_if.dco_in = (i == 1);
      @(negedge sample_clk);
      check("rst_p_up",      32'(pd_if.p_up),      32'd0);
      check("rst_p_down",    32'(pd_if.p_down),    32'd0);
      check("rst_phase_clk", 32'(pd_if.phase_clk), 32'd0);
      check("rst_phase_err", 32'(pd_if.phase_err), 32'd0);
      check("rst_dropped",   32'(pd_if.dropped),   32'd0);
    end
    pd_if.ref_in = 1'b0;
    pd_if.dco_in = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    check("idle_phase_clk", 32'(pd_if.phase_clk), 32'd0);

    // DCO lags by 6, with strobe latency check.
    measure(1'b0, 6, 1'b1);
    // DCO leads by 10.
    measure(1'b1, 10, 1'b0);
    // Dead zone: 1 cycle apart, then coincident.
    measure(1'b0, 1, 1'b0);
    measure(1'b1, 0, 1'b0);

    // Saturation by a second ref edge before any DCO edge.
    target = reports_done + 1;
    e.up = 1'b0; e.dn = 1'b1; e.err = CNT_W'(TIMEOUT);
    sb_q.push_back(e);
    pd_if.ref_in = 1'b1; cyc(2);
    pd_if.ref_in = 1'b0; cyc(2);
    pd_if.ref_in = 1'b1;
    wait_done(target);
    pd_if.ref_in = 1'b0;
    cyc(3);

    // Saturation by timeout (no DCO edge at all).
    target = reports_done + 1;
    sb_q.push_back(e);
    pd_if.ref_in = 1'b1;
    wait_done(target);
    pd_if.ref_in = 1'b0;
    cyc(3);

    // Randomised offsets and directions.
    for (int i = 0; i < 4; i++) begin
      measure(1'($urandom_range(0, 1)), int'($urandom_range(2, 40)), 1'b0);
    end

    // Edge during REPORT: dropped pulses once, no new measurement.
    target = reports_done + 1;
    e.up = 1'b0; e.dn = 1'b1; e.err = CNT_W'(3);
    sb_q.push_back(e);
    pd_if.ref_in = 1'b1; cyc(3);
    pd_if.dco_in = 1'b1; cyc(1);
    pd_if.dco_in = 1'b0;
    wait_pclk_high(n);
    pd_if.dco_in = 1'b1;
    @(negedge sample_clk);
    check("dropped_pre",   32'(pd_if.dropped), 32'd0);
    @(negedge sample_clk);
    check("dropped_pulse", 32'(pd_if.dropped), 32'd1);
    @(negedge sample_clk);
    check("dropped_post",  32'(pd_if.dropped), 32'd0);
    wait_done(target);
    cyc(20);
    check("no_extra_report", 32'(reports_done), 32'(target));
    check("sb_after_drop",   32'(sb_q.size()),  32'd0);
    pd_if.ref_in = 1'b0;
    pd_if.dco_in = 1'b0;
    cyc(3);

    // Reset in the second high cycle of phase_clk.
    e.up = 1'b0; e.dn = 1'b1; e.err = CNT_W'(4);
    sb_q.push_back(e);
    pd_if.ref_in = 1'b1; cyc(4);
    pd_if.dco_in = 1'b1;
    wait_pclk_high(n);
    check("pre_rst_p_down", 32'(pd_if.p_down), 32'd1);
    @(negedge sample_clk);
    check("pre_rst_phase_clk", 32'(pd_if.phase_clk), 32'd1);
    reset = 1'b1;
    @(negedge sample_clk);
    check("midrst_phase_clk", 32'(pd_if.phase_clk), 32'd0);
    check("midrst_p_down",    32'(pd_if.p_down),    32'd0);
    check("midrst_phase_err", 32'(pd_if.phase_err), 32'd0);
    pd_if.ref_in = 1'b0;
    pd_if.dco_in = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    check("post_rst_phase_clk", 32'(pd_if.phase_clk), 32'd0);

    // A clean measurement after the aborted one.
    measure(1'b1, 5, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
